// File: rtl/alu_pkg.sv
// Shared types for the two-requester ALU arbiter.
// Covers ALU op codes, arbiter FSM states and the captured request bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SR      = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RESP  = 2'b10
  } arb_state_e;

  typedef struct packed {
    logic [2:0]  cntrl;
    logic        useF7;
    logic        inv;
    logic [31:0] a;
    logic [31:0] b;
  } alu_req_t;

  // Packs one requester's port fields into the request bundle.
  function automatic alu_req_t pack_req(input logic [2:0] cntrl, input logic useF7,
                                        input logic inv, input logic [31:0] a,
                                        input logic [31:0] b);
    alu_req_t r;
    r.cntrl = cntrl;
    r.useF7 = useF7;
    r.inv   = inv;
    r.a     = a;
    r.b     = b;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin tie-break: a lone requester always wins,
// and on a tie the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       lastGrant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters.
// Each op takes IDLE (accept) -> ISSUE (drive ALU) -> RESP (hold result until consumed).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int PRIO_RESET = 0
) (
  input  logic        clk,
  input  logic        rstN,

  input  logic        reqValid_0,
  output logic        reqReady_0,
  input  logic [2:0]  reqCntrl_0,
  input  logic        reqUseF7_0,
  input  logic        reqInv_0,
  input  logic [31:0] reqA_0,
  input  logic [31:0] reqB_0,
  output logic        rspValid_0,
  input  logic        rspReady_0,
  output logic [31:0] rspResult_0,
  output logic        rspBranch_0,

  input  logic        reqValid_1,
  output logic        reqReady_1,
  input  logic [2:0]  reqCntrl_1,
  input  logic        reqUseF7_1,
  input  logic        reqInv_1,
  input  logic [31:0] reqA_1,
  input  logic [31:0] reqB_1,
  output logic        rspValid_1,
  input  logic        rspReady_1,
  output logic [31:0] rspResult_1,
  output logic        rspBranch_1,

  output logic [2:0]  aluCntrl,
  output logic        useF7,
  output logic        inv,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  input  logic [31:0] aluResult,
  input  logic        branchFlag
);

  // lastGrant resets to the opposite requester so PRIO_RESET wins the first tie.
  localparam logic LAST_RESET = (PRIO_RESET == 0) ? 1'b1 : 1'b0;

  arb_state_e state;
  arb_state_e stateNext;
  logic       owner;
  logic       lastGrant;
  alu_req_t   aluReq;
  alu_req_t   req0;
  alu_req_t   req1;
  logic [1:0] grant;
  logic       handshake;
  logic       grantOwner;
  logic       rspFire;

  assign req0 = pack_req(reqCntrl_0, reqUseF7_0, reqInv_0, reqA_0, reqB_0);
  assign req1 = pack_req(reqCntrl_1, reqUseF7_1, reqInv_1, reqA_1, reqB_1);

  rr_arbiter2 u_rr (
    .req       ({reqValid_1, reqValid_0}),
    .lastGrant (lastGrant),
    .grant     (grant)
  );

  always_comb begin
    reqReady_0 = rstN && (state == IDLE) && grant[0];
    reqReady_1 = rstN && (state == IDLE) && grant[1];
    handshake  = (reqValid_0 && reqReady_0) || (reqValid_1 && reqReady_1);
    grantOwner = grant[1];
    rspValid_0 = (state == RESP) && !owner;
    rspValid_1 = (state == RESP) && owner;
    rspFire    = owner ? rspReady_1 : rspReady_0;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (handshake) stateNext = ISSUE;
      ISSUE:   stateNext = RESP;
      RESP:    if (rspFire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lastGrant <= LAST_RESET;
    end else begin
      state <= stateNext;
      if (handshake) begin
        owner     <= grantOwner;
        lastGrant <= grantOwner;
      end
    end
  end

  // The ALU sees the captured op only during ISSUE and zeros otherwise.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      aluReq <= '0;
    end else if (handshake) begin
      aluReq <= grantOwner ? req1 : req0;
    end else if (state == ISSUE) begin
      aluReq <= '0;
    end
  end

  assign aluCntrl = aluReq.cntrl;
  assign useF7    = aluReq.useF7;
  assign inv      = aluReq.inv;
  assign srcA     = aluReq.a;
  assign srcB     = aluReq.b;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rspResult_0 <= '0;
      rspBranch_0 <= 1'b0;
      rspResult_1 <= '0;
      rspBranch_1 <= 1'b0;
    end else if (state == ISSUE) begin
      if (owner) begin
        rspResult_1 <= aluResult;
        rspBranch_1 <= branchFlag;
      end else begin
        rspResult_0 <= aluResult;
        rspBranch_0 <= branchFlag;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a transaction-level model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int PRIO_RESET = 0;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        reqValid_0, reqReady_0, reqUseF7_0, reqInv_0, rspValid_0, rspReady_0, rspBranch_0;
  logic        reqValid_1, reqReady_1, reqUseF7_1, reqInv_1, rspValid_1, rspReady_1, rspBranch_1;
  logic [2:0]  reqCntrl_0, reqCntrl_1, aluCntrl;
  logic [31:0] reqA_0, reqB_0, reqA_1, reqB_1, rspResult_0, rspResult_1;
  logic        useF7, inv, branchFlag;
  logic [31:0] srcA, srcB, aluResult;

  int checks = 0;
  int errors = 0;
  bit checkEn = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.PRIO_RESET(PRIO_RESET)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid_0(reqValid_0), .reqReady_0(reqReady_0), .reqCntrl_0(reqCntrl_0),
    .reqUseF7_0(reqUseF7_0), .reqInv_0(reqInv_0), .reqA_0(reqA_0), .reqB_0(reqB_0),
    .rspValid_0(rspValid_0), .rspReady_0(rspReady_0), .rspResult_0(rspResult_0),
    .rspBranch_0(rspBranch_0),
    .reqValid_1(reqValid_1), .reqReady_1(reqReady_1), .reqCntrl_1(reqCntrl_1),
    .reqUseF7_1(reqUseF7_1), .reqInv_1(reqInv_1), .reqA_1(reqA_1), .reqB_1(reqB_1),
    .rspValid_1(rspValid_1), .rspReady_1(rspReady_1), .rspResult_1(rspResult_1),
    .rspBranch_1(rspBranch_1),
    .aluCntrl(aluCntrl), .useF7(useF7), .inv(inv), .srcA(srcA), .srcB(srcB),
    .aluResult(aluResult), .branchFlag(branchFlag)
  );

  // Reference ALU: returns {branch, result}; branch is zero-test for add/sub, else result bit 0.
  function automatic logic [32:0] aluEval(input logic [2:0] c, input logic f7, input logic iv,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        br;
    case (c)
      3'd0:    r = f7 ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    r = (a < b) ? 32'd1 : 32'd0;
      3'd4:    r = a ^ b;
      3'd5:    r = f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    br = ((c == 3'd0) ? (r == 32'd0) : r[0]) ^ iv;
    return {br, r};
  endfunction

  assign {branchFlag, aluResult} = aluEval(aluCntrl, useF7, inv, srcA, srcB);

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: who is being served, how many edges since acceptance, what it must return.
  bit          mBusy = 0;
  int          mOwner = 0;
  int          mAge = 0;
  int          mLast = 1 - PRIO_RESET;
  logic [68:0] mDrive = '0;
  logic [32:0] mExp = '0;

  function automatic int pickWinner(input logic v0, input logic v1, input int last);
    if (v0 && v1) return 1 - last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(negedge rstN) begin
    mBusy = 0;
    mLast = 1 - PRIO_RESET;
  end

  always @(posedge clk) begin : modelStep
    int w;
    if (rstN) begin
      if (!mBusy) begin
        w = pickWinner(reqValid_0, reqValid_1, mLast);
        if (w >= 0) begin
          if (w == 0) mDrive = {reqCntrl_0, reqUseF7_0, reqInv_0, reqA_0, reqB_0};
          else        mDrive = {reqCntrl_1, reqUseF7_1, reqInv_1, reqA_1, reqB_1};
          mExp   = aluEval(mDrive[68:66], mDrive[65], mDrive[64], mDrive[63:32], mDrive[31:0]);
          mBusy  = 1;
          mAge   = 1;
          mOwner = w;
          mLast  = w;
        end
      end else if (mAge == 1) begin
        mAge = 2;
      end else if ((mOwner == 0) ? rspReady_0 : rspReady_1) begin
        mBusy = 0;
      end
    end
  end

  always @(negedge clk) begin : compareStep
    logic [1:0] eReady;
    logic [1:0] eValid;
    logic [68:0] eDrive;
    int w;
    if (checkEn) begin
      eReady = 2'b00;
      eValid = 2'b00;
      eDrive = '0;
      if (!rstN) begin
        checkOutput("rst_rspResult0", rspResult_0, 0);
        checkOutput("rst_rspResult1", rspResult_1, 0);
        checkOutput("rst_rspBranch", {rspBranch_1, rspBranch_0}, 0);
      end else if (!mBusy) begin
        w = pickWinner(reqValid_0, reqValid_1, mLast);
        if (w >= 0) eReady[w] = 1'b1;
      end else if (mAge == 1) begin
        eDrive = mDrive;
      end else begin
        eValid[mOwner] = 1'b1;
      end
      checkOutput("reqReady0", reqReady_0, eReady[0]);
      checkOutput("reqReady1", reqReady_1, eReady[1]);
      checkOutput("rspValid0", rspValid_0, eValid[0]);
      checkOutput("rspValid1", rspValid_1, eValid[1]);
      checkOutput("aluDrive", {aluCntrl, useF7, inv, srcA, srcB}, eDrive);
      if (eValid[0]) checkOutput("rsp0", {rspBranch_0, rspResult_0}, mExp);
      if (eValid[1]) checkOutput("rsp1", {rspBranch_1, rspResult_1}, mExp);
    end
  end

  task automatic applyStimulus(input int r, input logic v, input logic [2:0] c, input logic f7,
                               input logic iv, input logic [31:0] a, input logic [31:0] b);
    if (r == 0) begin
      reqValid_0 = v; reqCntrl_0 = c; reqUseF7_0 = f7; reqInv_0 = iv; reqA_0 = a; reqB_0 = b;
    end else begin
      reqValid_1 = v; reqCntrl_1 = c; reqUseF7_1 = f7; reqInv_1 = iv; reqA_1 = a; reqB_1 = b;
    end
  endtask

  task automatic idleCycles(input int n);
    reqValid_0 = 0; reqValid_1 = 0; rspReady_0 = 1; rspReady_1 = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int order[$];
    int expOrder[4];
    int n1;
    expOrder = '{0, 1, 0, 1};
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
    rspReady_0 = 0; rspReady_1 = 0;
    #2 rstN = 0;
    checkEn = 1;
    @(negedge clk);
    checkOutput("t0_rst_reqReady0", reqReady_0, 0);
    checkOutput("t0_rst_srcA", srcA, 0);
    @(posedge clk); #1 rstN = 1;

    // Single ADD from requester 0
    applyStimulus(0, 1, ADD_SUB, 0, 0, 32'd5, 32'd7);
    rspReady_0 = 1;
    @(negedge clk);
    checkOutput("t1_reqReady0_c0", reqReady_0, 1);
    @(posedge clk); #1 reqValid_0 = 0;
    @(negedge clk);
    checkOutput("t1_rspValid0_c1", rspValid_0, 0);
    checkOutput("t1_srcA_issue", srcA, 32'd5);
    checkOutput("t1_srcB_issue", srcB, 32'd7);
    @(negedge clk);
    checkOutput("t1_rspValid0_c2", rspValid_0, 1);
    checkOutput("t1_rspResult0", rspResult_0, 32'd12);
    checkOutput("t1_rspBranch0", rspBranch_0, 0);
    checkOutput("t1_srcA_resp", srcA, 0);
    @(negedge clk);
    checkOutput("t1_rspValid0_c3", rspValid_0, 0);
    checkOutput("t1_reqReady0_c3", reqReady_0, 0);

    // Tie: both valid continuously after reset
    @(posedge clk); #1 rstN = 0;
    @(posedge clk); #1 rstN = 1;
    applyStimulus(0, 1, AND, 0, 0, 32'hF0, 32'h3C);
    applyStimulus(1, 1, ADD_SUB, 1, 0, 32'd3, 32'd3);
    rspReady_0 = 1; rspReady_1 = 1;
    n1 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (reqReady_0) order.push_back(0);
      if (reqReady_1) order.push_back(1);
      if (rspValid_1) begin
        checkOutput("t2_sub_result", rspResult_1, 0);
        checkOutput("t2_sub_branch", rspBranch_1, 1);
        n1++;
      end
    end
    checkOutput("t2_grant_count", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++)
      checkOutput("t2_grant_order", order[i], expOrder[i]);
    checkOutput("t2_rsp1_count", n1, 2);
    @(posedge clk); #1;
    idleCycles(5);

    // Backpressure on requester 1 while requester 0 waits
    applyStimulus(1, 1, SLT, 0, 0, 32'hFFFF_FFFF, 32'd0);
    rspReady_1 = 0;
    @(posedge clk); #1;
    reqValid_1 = 0;
    applyStimulus(0, 1, OR, 0, 0, 32'h11, 32'h22);
    @(negedge clk);
    checkOutput("t3_reqReady0_issue", reqReady_0, 0);
    repeat (4) begin
      @(negedge clk);
      checkOutput("t3_rspValid1", rspValid_1, 1);
      checkOutput("t3_rspResult1", rspResult_1, 32'd1);
      checkOutput("t3_rspBranch1", rspBranch_1, 1);
      checkOutput("t3_reqReady0", reqReady_0, 0);
    end
    @(posedge clk); #1 rspReady_1 = 1;
    @(posedge clk); #1;
    idleCycles(5);

    // Operands change after handshake
    applyStimulus(0, 1, XOR, 0, 0, 32'hFFFF_0000, 32'h00FF_FF00);
    @(posedge clk); #1;
    applyStimulus(0, 0, XOR, 0, 0, 32'h1234_5678, 32'h8765_4321);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_rspValid0", rspValid_0, 1);
    checkOutput("t4_xor_result", rspResult_0, 32'hFF00_FF00);
    @(posedge clk); #1;
    idleCycles(3);

    // Asynchronous reset during ISSUE
    applyStimulus(0, 1, ADD_SUB, 0, 0, 32'd1, 32'd2);
    @(posedge clk); #1;
    reqValid_0 = 0;
    #2 rstN = 0;
    #1;
    checkOutput("t5_srcA_rst", srcA, 0);
    checkOutput("t5_rspValid_rst", {rspValid_1, rspValid_0}, 0);
    checkOutput("t5_reqReady_rst", {reqReady_1, reqReady_0}, 0);
    @(posedge clk); #1;
    applyStimulus(0, 1, OR, 0, 0, 32'h5, 32'h6);
    applyStimulus(1, 1, OR, 0, 0, 32'h7, 32'h8);
    rstN = 1;
    @(negedge clk);
    checkOutput("t5_tie_ready0", reqReady_0, 1);
    checkOutput("t5_tie_ready1", reqReady_1, 0);
    checkOutput("t5_no_rsp", {rspValid_1, rspValid_0}, 0);
    @(posedge clk); #1;
    idleCycles(5);

    // Randomized traffic
    repeat (800) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      applyStimulus(1, 1'($urandom_range(0, 1)), 3'($urandom), 1'($urandom), 1'($urandom),
                    $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
      rspReady_0 = ($urandom_range(0, 9) < 6);
      rspReady_1 = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 149) == 0) begin
        rstN = 0;
        #2 rstN = 1;
      end
      @(posedge clk); #1;
    end
    idleCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
